// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer bank: channel state encoding,
// the default prescaler length and the packed-bus slice helper.
package timer_pkg;

  typedef enum logic {T_IDLE, T_RUN} timer_state_t;

  localparam int DEFAULT_PRESCALE = 500;

  // Lowest bit of channel ch inside a bus packed ch-major, width bits each
  function automatic int chLsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Shared prescaler: divides clk into count-unit ticks while any channel runs,
// and parks at zero when nothing is busy so a fresh start gets a full unit.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = enable && (cnt_q == PW'(PRESCALE - 1));

  // Next count: advance while enabled, wrap on the tick, otherwise hold at zero
  always_comb begin
    cnt_d = '0;
    if (enable && !tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent down-counting timers sharing one prescaler.
// Each channel runs one-shot or auto-reload, can be restarted or aborted,
// and exposes its live remaining count.
// Optional macro TIMER_PAUSE_EN adds a per-channel pause input that freezes
// a running channel's count while keeping it busy.
module timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
`ifdef TIMER_PAUSE_EN
  input  logic [NUM_CH-1:0]       pause,
`endif
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expired,
  output logic [NUM_CH*CNT_W-1:0] remaining
);

  logic tick;
  logic anyBusy;

  assign anyBusy = |busy;

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (anyBusy),
    .tick   (tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam int LSB = chLsb(i, CNT_W);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             exp_q, exp_d;
    logic             holdCh;
    logic [CNT_W-1:0] loadCh;

    assign loadCh = load_val[LSB +: CNT_W];

`ifdef TIMER_PAUSE_EN
    assign holdCh = pause[i];
`else
    assign holdCh = 1'b0;
`endif

    // Channel next state: start beats stop, stop beats a tick
    always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      exp_d    = 1'b0;
      if (start[i]) begin
        reload_d = loadCh;
        mode_d   = periodic[i];
        if (loadCh != '0) begin
          rem_d   = loadCh;
          state_d = T_RUN;
        end else begin
          rem_d   = '0;
          state_d = T_IDLE;
          exp_d   = 1'b1;
        end
      end else if (stop[i]) begin
        rem_d   = '0;
        state_d = T_IDLE;
      end else if ((state_q == T_RUN) && tick && !holdCh) begin
        if (rem_q > CNT_W'(1)) begin
          rem_d = rem_q - 1'b1;
        end else begin
          exp_d = 1'b1;
          if (mode_q) begin
            rem_d = reload_q;
          end else begin
            rem_d   = '0;
            state_d = T_IDLE;
          end
        end
      end
    end

    // Channel registers, all cleared by reset so a reset never leaves a pulse
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q  <= T_IDLE;
        rem_q    <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        exp_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        rem_q    <= rem_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        exp_q    <= exp_d;
      end
    end

    assign busy[i]                 = (state_q == T_RUN);
    assign expired[i]              = exp_q;
    assign remaining[LSB +: CNT_W] = rem_q;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank with PRESCALE=4, CNT_W=8, NUM_CH=4.
// Cycle 0 is the cycle in which a start strobe is driven; outputs are
// sampled 1ns after each rising edge, before the next inputs are driven.
module tb_timer_bank;

  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH*CNT_W-1:0] load_val;
`ifdef TIMER_PAUSE_EN
  logic [NUM_CH-1:0]       pause;
`endif
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       expired;
  logic [NUM_CH*CNT_W-1:0] remaining;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         ch;
    logic [7:0] load;
    logic       per;
    int         expCycle;
    int         finalBusy;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] remTbl [13];

  timer_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .load_val  (load_val),
`ifdef TIMER_PAUSE_EN
    .pause     (pause),
`endif
    .busy      (busy),
    .expired   (expired),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] remOf(input int ch);
    return remaining[ch*CNT_W +: CNT_W];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic [3:0] sp,
                               input logic [3:0] per, input logic [31:0] lv);
    start    = st;
    stop     = sp;
    periodic = per;
    load_val = lv;
    step();
    start = '0;
    stop  = '0;
  endtask

  task automatic doReset();
    reset    = 1'b0;
    start    = '0;
    stop     = '0;
    periodic = '0;
    load_val = '0;
`ifdef TIMER_PAUSE_EN
    pause    = '0;
`endif
    step();
    step();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_expired", 32'(expired), 0);
    checkOutput("rst_remaining", remaining, 0);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int first, pulses, second;
    logic [31:0] lv;

    vecs[0] = '{ch: 0, load: 8'd3, per: 1'b0, expCycle: 13, finalBusy: 0};
    vecs[1] = '{ch: 2, load: 8'd0, per: 1'b0, expCycle: 1,  finalBusy: 0};
    vecs[2] = '{ch: 3, load: 8'd1, per: 1'b0, expCycle: 5,  finalBusy: 0};
    vecs[3] = '{ch: 1, load: 8'd2, per: 1'b1, expCycle: 9,  finalBusy: 1};
    vecs[4] = '{ch: 0, load: 8'd7, per: 1'b0, expCycle: 29, finalBusy: 0};
    vecs[5] = '{ch: 2, load: 8'd4, per: 1'b0, expCycle: 17, finalBusy: 0};
    remTbl  = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2, 8'd2,
                8'd1, 8'd1, 8'd1, 8'd1, 8'd0};

    // Table of single-channel runs: first expiry cycle and pulse count
    for (int r = 0; r < 6; r++) begin
      doReset();
      lv = '0;
      lv[vecs[r].ch*CNT_W +: CNT_W] = vecs[r].load;
      applyStimulus(4'(1 << vecs[r].ch), 4'b0000,
                    vecs[r].per ? 4'(1 << vecs[r].ch) : 4'b0000, lv);
      checkOutput("tbl_rem_start", 32'(remOf(vecs[r].ch)), 32'(vecs[r].load));
      checkOutput("tbl_busy_start", 32'(busy[vecs[r].ch]), (vecs[r].load != 0) ? 1 : 0);
      first  = -1;
      pulses = 0;
      while (cyc <= vecs[r].expCycle + 6) begin
        if (expired[vecs[r].ch]) begin
          pulses++;
          if (first < 0) first = cyc;
        end
        step();
      end
      checkOutput("tbl_first_exp", first, vecs[r].expCycle);
      checkOutput("tbl_pulses", pulses, 1);
      checkOutput("tbl_busy_end", 32'(busy[vecs[r].ch]), vecs[r].finalBusy);
    end

    // One-shot ch0 load 3: remaining stepping, expiry and busy drop at cycle 13
    doReset();
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0003);
    while (cyc <= 13) begin
      checkOutput("os_remaining", 32'(remOf(0)), 32'(remTbl[cyc-1]));
      checkOutput("os_expired", 32'(expired[0]), (cyc == 13) ? 1 : 0);
      checkOutput("os_busy", 32'(busy[0]), (cyc == 13) ? 0 : 1);
      step();
    end

    // Periodic ch1 load 2: pulses at 9 and 17, stop at 20 suppresses 25
    doReset();
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 32'h0000_0200);
    first = -1; second = -1; pulses = 0;
    while (cyc <= 30) begin
      if (expired[1]) begin
        pulses++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (cyc == 9) begin
        checkOutput("per_reload_rem", 32'(remOf(1)), 2);
        checkOutput("per_busy", 32'(busy[1]), 1);
      end
      if (cyc == 21) begin
        stop = '0;
        checkOutput("per_stop_rem", 32'(remOf(1)), 0);
        checkOutput("per_stop_busy", 32'(busy[1]), 0);
      end
      if (cyc == 20) stop = 4'b0010;
      step();
    end
    checkOutput("per_first", first, 9);
    checkOutput("per_second", second, 17);
    checkOutput("per_pulses", pulses, 2);

    // Restart ch0 load 5 with load 2 at cycle 10: one pulse at 17 only
    doReset();
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 32'h0000_0005);
    first = -1; pulses = 0;
    while (cyc <= 40) begin
      if (expired[0]) begin
        pulses++;
        if (first < 0) first = cyc;
      end
      if (cyc == 11) begin
        start = '0;
        checkOutput("rs_rem", 32'(remOf(0)), 2);
      end
      if (cyc == 10) begin
        start    = 4'b0001;
        load_val = 32'h0000_0002;
      end
      step();
    end
    checkOutput("rs_first", first, 17);
    checkOutput("rs_pulses", pulses, 1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 32'h0000_0003);
    checkOutput("ss_busy", 32'(busy[0]), 1);
    checkOutput("ss_rem", 32'(remOf(0)), 3);

    // All channels load 1 together: joint expiry at cycle 5
    doReset();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 32'h0101_0101);
    while (cyc <= 8) begin
      if (cyc == 4) checkOutput("all_exp_c4", 32'(expired), 0);
      if (cyc == 5) begin
        checkOutput("all_exp_c5", 32'(expired), 32'hF);
        checkOutput("all_busy_c5", 32'(busy), 0);
      end
      if (cyc == 6) checkOutput("all_exp_c6", 32'(expired), 0);
      step();
    end

    // Second run aborted by reset at cycle 3: outputs clear at once, no pulse
    cyc = 0;
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 32'h0101_0101);
    while (cyc < 3) step();
    reset = 1'b0;
    #1;
    checkOutput("ar_busy", 32'(busy), 0);
    checkOutput("ar_expired", 32'(expired), 0);
    checkOutput("ar_remaining", remaining, 0);
    step();
    step();
    reset  = 1'b1;
    pulses = 0;
    while (cyc <= 12) begin
      if (expired != '0) pulses++;
      step();
    end
    checkOutput("ar_no_pulse", pulses, 0);
    checkOutput("ar_busy_end", 32'(busy), 0);

`ifdef TIMER_PAUSE_EN
    // Pause ch3 over cycles 5..14: two ticks swallowed, expiry moves 13 -> 21
    doReset();
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 32'h0300_0000);
    first = -1; pulses = 0;
    while (cyc <= 30) begin
      if (expired[3]) begin
        pulses++;
        if (first < 0) first = cyc;
      end
      if (cyc == 14) begin
        checkOutput("pz_rem", 32'(remOf(3)), 2);
        checkOutput("pz_busy", 32'(busy[3]), 1);
      end
      if (cyc == 5)  pause = 4'b1000;
      if (cyc == 15) pause = 4'b0000;
      step();
    end
    checkOutput("pz_first", first, 21);
    checkOutput("pz_pulses", pulses, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the single-count 1-second timer.
- NUM_CH independent down-counting timers share one prescaler. Each channel supports one-shot or periodic mode, runtime load values, stop/restart, and readback of remaining time.
- Serves the ticket-machine controller for coin-insert timeout, display hold, gate-open window and the idle-return timer.

Parameters:
- NUM_CH, 4, number of timer channels (1..16)
- CNT_W, 16, width of per-channel load/remaining count
- PRESCALE, 500, clk cycles per count unit (>=2); prescaler width is $clog2(PRESCALE)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  NUM_CH  per-channel start/restart strobe, sampled each cycle
- stop  in  NUM_CH  per-channel abort strobe
- periodic  in  NUM_CH  mode, sampled with start: 1=auto-reload, 0=one-shot
- load_val  in  NUM_CH*CNT_W  count per channel; channel i uses bits [i*CNT_W +: CNT_W]
- busy  out  NUM_CH  channel in RUN
- expired  out  NUM_CH  one-cycle pulse at terminal count
- remaining  out  NUM_CH*CNT_W  live count, same packing as load_val

Behaviour:
- Reset (asynchronous, active-low): all channels IDLE; busy=0, expired=0, remaining=0, prescaler=0, reload and mode registers=0. Reset mid-count aborts with no expired pulse.
- Prescaler:
  - Counts 0..PRESCALE-1 while any busy bit is 1.
  - Held at 0 when no channel is busy.
  - tick is a combinational 1 when count==PRESCALE-1 and any busy=1; the counter wraps to 0 on the same edge.
- Per-channel FSM, states IDLE and RUN. Per-edge priority: start > stop > tick.
- start=1, any state:
  - reload_reg <= load_val and mode_reg <= periodic.
  - If load_val!=0: remaining <= load_val, go to RUN. Restart in RUN discards the old count without expiring.
  - If load_val==0: stay or go IDLE, remaining <= 0, expired pulses next cycle.
- stop=1 (no start): go IDLE, remaining <= 0, no expired.
- RUN with tick:
  - remaining>1: remaining <= remaining-1.
  - remaining==1 and mode_reg=1: expired pulse, remaining <= reload_reg, stay in RUN.
  - remaining==1 and mode_reg=0: expired pulse, remaining <= 0, go IDLE.
- Timing and outputs:
  - expired is registered: high exactly one cycle, in the cycle after the terminal tick.
  - busy is a registered state decode.
  - remaining is the register value, with no added latency.
- Latency: if all channels were idle, start sampled at cycle 0 with load N gives expired high in cycle N*PRESCALE+1. If other channels are already running, the first count unit may be shorter by up to PRESCALE-1 cycles; this is accepted.
- Channels are fully independent. Simultaneous starts and expiries on different channels are all honoured in the same cycle.
- Arithmetic is unsigned CNT_W. Decrement never underflows, because 0 is never held in RUN.

Optional Feature:
- Macro: TIMER_PAUSE_EN.
- Defined:
  - Adds input `pause`, NUM_CH wide.
  - A channel in RUN with pause=1 ignores ticks: remaining and busy are held.
  - start and stop still act with normal priority.
  - A paused channel counts as busy for prescaler enable.
- Undefined: the port is absent and channels never pause.

Decomposition:
- Package timer_pkg:
  - typedef enum logic {T_IDLE, T_RUN} timer_state_t
  - localparam default PRESCALE
  - function for channel slice index
- Sub-module timer_prescaler (params PRESCALE; ports clk, reset, enable, tick).
- timer_bank instantiates one timer_prescaler plus a generate loop of channel logic.

Test Plan (PRESCALE=4, CNT_W=8, NUM_CH=4):
- ch0 one-shot, start with load=3 at cycle 0 -> expired[0] high only in cycle 13; busy[0] falls the same cycle; remaining steps 3,2,1,0.
- ch1 periodic, load=2 -> expired[1] pulses at cycles 9, 17, 25; busy stays 1; stop at cycle 20 -> remaining=0, busy=0, no pulse at 25.
- ch2 start with load=0 -> expired[2] high in cycle 1; busy[2] never asserts.
- ch0 running with load=5, restart at cycle 10 with load=2 -> no expiry from the old count; one expired pulse 2 units later; start+stop in the same cycle -> start wins.
- All 4 channels started with load=1 in the same cycle -> all expired bits high together in cycle 5; reset asserted at cycle 3 of a second run -> all outputs 0 immediately, no pulse.
- TIMER_PAUSE_EN: ch3 load=3, pause held for 10 cycles mid-count -> remaining frozen; expiry delayed by exactly the paused whole-tick count.
